// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the datapath data-memory interface.
// Accepts a load/store through a valid/ready handshake, spends WAIT_CYCLES
// in WAIT, then issues a one-cycle response carrying extended load data
// and an error flag. Storage is 2**(DM_ADDRESS-2) 32-bit words, cleared on reset.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; ready is high only in IDLE
//   MemRead/MemWrite  load/store request
//   Funct3            RV32I load/store size/sign encoding
//   addr, wdata       byte address, right-aligned store data
//   rsp_valid         one-cycle response strobe
//   rdata, err        extended load data, rejected-request flag
module dmem_responder #(
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err
);

  localparam int unsigned IDX_W = DM_ADDRESS - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rd_q, wr_q;
  logic [2:0]              f3_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    accept_c, commit_c, req_err_c;
  logic                    sel_rd_c, sel_wr_c;
  logic [2:0]              sel_f3_c;
  logic [DM_ADDRESS-1:0]   sel_addr_c;
  logic [DATA_W-1:0]       sel_wdata_c;
  logic [DATA_W-1:0]       word_c, load_c, merged_c, aligned_c, bitmask_c;
  logic [7:0]              byte_c;
  logic [15:0]             half_c;
  logic [3:0]              lanes_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = (state_q == S_IDLE) && req_valid && (MemRead || MemWrite);
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait cycles the access happens on the accepting edge, so the
  // live request is used while still in IDLE; otherwise the latched copy.
  always_comb begin
    sel_rd_c    = (state_q == S_IDLE) ? MemRead  : rd_q;
    sel_wr_c    = (state_q == S_IDLE) ? MemWrite : wr_q;
    sel_f3_c    = (state_q == S_IDLE) ? Funct3   : f3_q;
    sel_addr_c  = (state_q == S_IDLE) ? addr     : addr_q;
    sel_wdata_c = (state_q == S_IDLE) ? wdata    : wdata_q;
    commit_c    = (state_d == S_RESP) && (state_q != S_RESP);
  end

  // Request legality: conflicting op, illegal encoding, or misalignment
  always_comb begin
    req_err_c = 1'b0;
    if (sel_rd_c && sel_wr_c) req_err_c = 1'b1;
    if (sel_rd_c && (sel_f3_c == 3'b011 || sel_f3_c == 3'b110 || sel_f3_c == 3'b111))
      req_err_c = 1'b1;
    if (sel_wr_c && (sel_f3_c[2] || sel_f3_c == 3'b011)) req_err_c = 1'b1;
    if (sel_f3_c[1:0] == 2'b01 && sel_addr_c[0]) req_err_c = 1'b1;
    if (sel_f3_c == 3'b010 && sel_addr_c[1:0] != 2'b00) req_err_c = 1'b1;
  end

  // Lane selection, load extension and store merge
  always_comb begin
    word_c  = mem[sel_addr_c[DM_ADDRESS-1:2]];
    byte_c  = word_c[{sel_addr_c[1:0], 3'b000} +: 8];
    half_c  = sel_addr_c[1] ? word_c[31:16] : word_c[15:0];
    load_c  = '0;
    case (sel_f3_c)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b010:  load_c = word_c;
      3'b100:  load_c = {24'h0, byte_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = '0;
    endcase
    lanes_c   = 4'b1111;
    aligned_c = sel_wdata_c;
    case (sel_f3_c[1:0])
      2'b00: begin
        lanes_c   = 4'(4'b0001 << sel_addr_c[1:0]);
        aligned_c = {4{sel_wdata_c[7:0]}};
      end
      2'b01: begin
        lanes_c   = sel_addr_c[1] ? 4'b1100 : 4'b0011;
        aligned_c = {2{sel_wdata_c[15:0]}};
      end
      default: ;
    endcase
    bitmask_c = {{8{lanes_c[3]}}, {8{lanes_c[2]}}, {8{lanes_c[1]}}, {8{lanes_c[0]}}};
    merged_c  = (word_c & ~bitmask_c) | (aligned_c & bitmask_c);
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      rd_q    <= MemRead;
      wr_q    <= MemWrite;
      f3_q    <= Funct3;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Storage; a store commits on the edge entering RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit_c && sel_wr_c && !req_err_c) begin
      mem[sel_addr_c[DM_ADDRESS-1:2]] <= merged_c;
    end
  end

  // Registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      if (commit_c) begin
        err   <= req_err_c;
        rdata <= (sel_rd_c && !req_err_c) ? load_c : '0;
      end
    end
  end

endmodule
